// File: rtl/data_delay_scan.sv
// Sweeps all 32 delay taps, judges each against a training pattern, then centres
// the delay in the widest passing window and applies it through the delay-reset controller.
module data_delay_scan #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] PATTERN = 'hA5,
    parameter int                SAMPLES = 16,
    parameter int                SETTLE  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              delay_rst_in,
    input  logic              delay_err,
    output logic [4:0]        delay_tap,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [31:0]       pass_map,
    output logic [5:0]        best_len
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLING,
        SAMPLE,
        NEXT,
        ANALYZE,
        APPLY,
        FINISH
    } state_t;

    state_t     state;
    logic [7:0] settle_cnt;
    logic [7:0] sample_cnt;
    logic       sample_ok;
    logic [4:0] scan_idx;
    logic [4:0] cur_start;
    logic [5:0] cur_len;
    logic [4:0] best_start;

    logic       bit_now;
    logic       sample_ok_n;
    logic [5:0] run_len_n;
    logic [4:0] run_start_n;
    logic [5:0] best_len_n;
    logic [4:0] best_start_n;
    logic [5:0] half_len;
    logic [4:0] chosen_tap;

    // Window tracking for the bit under scan; the best run is updated as it grows,
    // so a run reaching bit 31 is covered and strict '>' keeps the lowest start on ties.
    always_comb begin
        bit_now      = pass_map[scan_idx];
        sample_ok_n  = sample_ok && (data_in == PATTERN) && !delay_rst_in;
        run_len_n    = 6'd0;
        run_start_n  = cur_start;
        if (bit_now) begin
            run_len_n   = cur_len + 6'd1;
            run_start_n = (cur_len == 6'd0) ? scan_idx : cur_start;
        end
        best_len_n   = best_len;
        best_start_n = best_start;
        if (run_len_n > best_len) begin
            best_len_n   = run_len_n;
            best_start_n = run_start_n;
        end
        half_len   = (best_len_n - 6'd1) >> 1;
        chosen_tap = best_start_n + half_len[4:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            delay_tap  <= 5'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            pass_map   <= 32'd0;
            best_len   <= 6'd0;
            settle_cnt <= 8'd0;
            sample_cnt <= 8'd0;
            sample_ok  <= 1'b0;
            scan_idx   <= 5'd0;
            cur_start  <= 5'd0;
            cur_len    <= 6'd0;
            best_start <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        fail       <= 1'b0;
                        pass_map   <= 32'd0;
                        best_len   <= 6'd0;
                        delay_tap  <= 5'd0;
                        settle_cnt <= 8'd0;
                        state      <= SETTLING;
                    end
                end
                SETTLING: begin
                    if (delay_rst_in) begin
                        settle_cnt <= 8'd0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        if (delay_err) begin
                            pass_map[delay_tap] <= 1'b0;
                            state               <= NEXT;
                        end else begin
                            sample_cnt <= 8'd0;
                            sample_ok  <= 1'b1;
                            state      <= SAMPLE;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                SAMPLE: begin
                    sample_ok <= sample_ok_n;
                    if (sample_cnt == SAMPLE_LAST) begin
                        pass_map[delay_tap] <= sample_ok_n;
                        state               <= NEXT;
                    end else begin
                        sample_cnt <= sample_cnt + 8'd1;
                    end
                end
                NEXT: begin
                    if (delay_tap != 5'd31) begin
                        delay_tap  <= delay_tap + 5'd1;
                        settle_cnt <= 8'd0;
                        state      <= SETTLING;
                    end else begin
                        scan_idx   <= 5'd0;
                        cur_start  <= 5'd0;
                        cur_len    <= 6'd0;
                        best_start <= 5'd0;
                        best_len   <= 6'd0;
                        state      <= ANALYZE;
                    end
                end
                ANALYZE: begin
                    cur_len    <= run_len_n;
                    cur_start  <= run_start_n;
                    best_len   <= best_len_n;
                    best_start <= best_start_n;
                    if (scan_idx == 5'd31) begin
                        if (best_len_n != 6'd0) begin
                            delay_tap  <= chosen_tap;
                            settle_cnt <= 8'd0;
                            state      <= APPLY;
                        end else begin
                            delay_tap <= 5'd0;
                            fail      <= 1'b1;
                            state     <= FINISH;
                        end
                    end else begin
                        scan_idx <= scan_idx + 5'd1;
                    end
                end
                APPLY: begin
                    if (delay_rst_in) begin
                        settle_cnt <= 8'd0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        fail  <= delay_err;
                        state <= FINISH;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_delay_scan.sv
// Bench for data_delay_scan: a delay-reset controller model plus a table of sweep
// scenarios whose expected results are queued at start and checked at done.
module tb_data_delay_scan;

    localparam logic [7:0] PAT = 8'hA5;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  data_in;
    logic        delay_rst_in;
    logic        delay_err;
    logic [4:0]  delay_tap;
    logic        busy;
    logic        done;
    logic        fail;
    logic [31:0] pass_map;
    logic [5:0]  best_len;

    logic [31:0] valid_map = 32'd0;
    logic [5:0]  err_tap   = 6'd32;
    logic [4:0]  prev_tap  = 5'd0;
    int          pulse_cnt = 0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] valid;
        logic [5:0]  etap;
        logic [31:0] pmap;
        logic [5:0]  blen;
        logic [4:0]  tap;
        logic        fl;
    } vec_t;

    vec_t vecs[5];
    vec_t exp_q[$];

    data_delay_scan #(.DATA_W(8), .PATTERN(PAT), .SAMPLES(16), .SETTLE(16)) dut (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .delay_rst_in(delay_rst_in), .delay_err(delay_err), .delay_tap(delay_tap),
        .busy(busy), .done(done), .fail(fail), .pass_map(pass_map), .best_len(best_len)
    );

    always #10 clk = ~clk;

    // Controller model: a 5-cycle tap-load reset pulse after every tap change.
    always @(posedge clk) begin
        prev_tap <= delay_tap;
        if (delay_tap != prev_tap)
            pulse_cnt <= 5;
        else if (pulse_cnt != 0)
            pulse_cnt <= pulse_cnt - 1;
    end

    assign delay_rst_in = (pulse_cnt != 0);
    assign delay_err    = ({1'b0, delay_tap} == err_tap);
    assign data_in      = valid_map[delay_tap] ? PAT : ~PAT;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        valid_map = v.valid;
        err_tap   = v.etap;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        exp_q.push_back(v);
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
        checkOutput("done_cleared", {31'd0, done}, 32'd0);
    endtask

    task automatic waitResult(input string tag);
        vec_t e;
        int   n = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL %s_timeout: done got 0 expected 1", tag);
        end
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_queue: got empty expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            repeat (3) @(negedge clk);
            checkOutput({tag, "_pass_map"}, pass_map, e.pmap);
            checkOutput({tag, "_best_len"}, {26'd0, best_len}, {26'd0, e.blen});
            checkOutput({tag, "_tap"}, {27'd0, delay_tap}, {27'd0, e.tap});
            checkOutput({tag, "_fail"}, {31'd0, fail}, {31'd0, e.fl});
            checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
            checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_tap"}, {27'd0, delay_tap}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_fail"}, {31'd0, fail}, 32'd0);
        checkOutput({tag, "_pass_map"}, pass_map, 32'd0);
        checkOutput({tag, "_best_len"}, {26'd0, best_len}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{valid: 32'h0003FC00, etap: 6'd32, pmap: 32'h0003FC00, blen: 6'd8,  tap: 5'd13, fl: 1'b0};
        vecs[1] = '{valid: 32'h0070001C, etap: 6'd32, pmap: 32'h0070001C, blen: 6'd3,  tap: 5'd3,  fl: 1'b0};
        vecs[2] = '{valid: 32'h00000000, etap: 6'd32, pmap: 32'h00000000, blen: 6'd0,  tap: 5'd0,  fl: 1'b1};
        vecs[3] = '{valid: 32'hFFFFFFFF, etap: 6'd32, pmap: 32'hFFFFFFFF, blen: 6'd32, tap: 5'd15, fl: 1'b0};
        vecs[4] = '{valid: 32'h0003FC00, etap: 6'd12, pmap: 32'h0003EC00, blen: 6'd5,  tap: 5'd15, fl: 1'b0};

        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        checkCleared("reset");
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
            waitResult($sformatf("vec%0d", i));
        end

        // A second start mid-sweep must not restart the tap walk.
        begin
            int n = 0;
            applyStimulus(vecs[0]);
            while (delay_tap != 5'd5 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            start = 1'b1;
            @(negedge clk) start = 1'b0;
            checkOutput("restart_ignored", {31'd0, (delay_tap >= 5'd5)}, 32'd1);
            checkOutput("restart_busy", {31'd0, busy}, 32'd1);
            waitResult("restart");
        end

        // Reset in the middle of tap 7 sampling clears everything, then a fresh sweep.
        begin
            int n = 0;
            valid_map = 32'hFFFFFFFF;
            err_tap   = 6'd32;
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
            while (delay_tap != 5'd7 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            repeat (28) @(negedge clk);
            checkOutput("mid_tap7", {27'd0, delay_tap}, 32'd7);
            reset = 1'b1;
            start = 1'b1;
            @(negedge clk);
            checkCleared("midreset");
            reset = 1'b0;
            start = 1'b0;
            repeat (2) @(negedge clk);
            checkCleared("idle_after_reset");
            applyStimulus(vecs[0]);
            waitResult("after_reset");
        end

        // done and the result hold while idle.
        repeat (20) @(negedge clk);
        checkOutput("hold_done", {31'd0, done}, 32'd1);
        checkOutput("hold_tap", {27'd0, delay_tap}, 32'd13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_delay_scan.md
DATA_DELAY_SCAN -- requirements
Module: data_delay_scan

Interface
REQ-001 Parameter DATA_W, default 8, width of the deserialized data word compared per cycle.
REQ-002 Parameter PATTERN, default 8'hA5, expected training word during the sweep.
REQ-003 Parameter SAMPLES, default 16, compare cycles per tap (range 1-255).
REQ-004 Parameter SETTLE, default 16, consecutive cycles delay_rst_in must be low before a tap is judged (range 8-255).
REQ-005 clk  input  1  clock, 50 MHz or lower, shared with the delay-reset controller.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  one-cycle pulse that begins a sweep.
REQ-008 data_in  input  DATA_W  deserialized word from the delayed data lane.
REQ-009 delay_rst_in  input  1  active-high tap-load reset issued by the delay-reset controller.
REQ-010 delay_err  input  1  controller error flag (tap readback mismatch).
REQ-011 delay_tap  output  5  tap value driven to the delay-reset controller.
REQ-012 busy  output  1  high while a sweep or final tap application is in progress.
REQ-013 done  output  1  level, high from sweep completion until the next accepted start.
REQ-014 fail  output  1  level, high with done when no tap passed.
REQ-015 pass_map  output  32  bit n = 1 if tap n passed in the last sweep.
REQ-016 best_len  output  6  length of the chosen passing window (0-32).

Function
REQ-017 States SHALL be IDLE, SETTLE, SAMPLE, NEXT, ANALYZE, APPLY, FINISH.
REQ-018 IDLE: start=1 -> next cycle busy=1, done=0, fail=0, pass_map=0, best_len=0, delay_tap=0, settle counter=0, state SETTLE.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 SETTLE: counter clears on any cycle delay_rst_in=1, else increments; at counter==SETTLE-1 with delay_rst_in=0 -> SAMPLE if delay_err=0, else pass_map[delay_tap]<=0 and NEXT.
REQ-021 SAMPLE: exactly SAMPLES consecutive cycles compare data_in to PATTERN; any mismatch -> tap fails; all equal -> pass_map[delay_tap]<=1; then NEXT.
REQ-022 delay_rst_in=1 during SAMPLE SHALL fail the tap.
REQ-023 NEXT: delay_tap<31 -> delay_tap+1, counter=0, SETTLE; delay_tap==31 -> ANALYZE; no wrap to 0.
REQ-024 ANALYZE SHALL scan pass_map bits 0..31, one bit per cycle (32 cycles), tracking the current run start/length and the best run.
REQ-025 A run ending at bit 31 SHALL be evaluated; on equal length the lowest-start run SHALL be kept.
REQ-026 Chosen tap = best_start + (best_len-1)/2, integer floor, 5-bit result.
REQ-027 best_len>0 -> delay_tap<=chosen tap, counter=0, APPLY; best_len==0 -> delay_tap<=0, fail<=1, FINISH.
REQ-028 APPLY: same settle rule as REQ-020; on completion FINISH, fail<=delay_err.
REQ-029 FINISH: busy<=0, done<=1, state IDLE; delay_tap, pass_map, best_len hold until next accepted start.
REQ-030 Sweep SHALL not depend on delay_rst_in becoming high; a tap equal to the controller's current tap settles after SETTLE low cycles.

Reset
REQ-031 reset=1 SHALL, on the next clk edge, force IDLE, delay_tap=0, busy=0, done=0, fail=0, pass_map=0, best_len=0, all counters 0, including mid-sweep.
REQ-032 reset SHALL take priority over start in the same cycle.

Verification
REQ-033 Pattern valid only on taps 10-17, controller model pulses delay_rst_in 5 cycles per change -> pass_map=32'h0003FC00, best_len=8, delay_tap=13, done=1, fail=0.
REQ-034 Passes on taps 2-4 and 20-22 -> best_len=3, delay_tap=3 (lowest window wins).
REQ-035 Never valid pattern -> pass_map=0, best_len=0, delay_tap=0, done=1, fail=1.
REQ-036 All taps valid -> pass_map=32'hFFFFFFFF, best_len=32, delay_tap=15.
REQ-037 Valid taps 10-17 but delay_err=1 while tap=12 settles -> pass_map=32'h0003EC00, best_len=5, delay_tap=15.
REQ-038 reset pulsed during tap 7 SAMPLE, then start -> all outputs 0 after reset; fresh sweep starts at tap 0 and reproduces REQ-033 result.
